// File: rtl/stp_frame_collector_if.sv
// Sample/frame bus between a sample source and stp_frame_collector.
// master: source of samples, sink of frames. slave: the collector.
interface stp_frame_collector_if #(
  parameter int IN_W = 18
);
  logic                   data_valid;
  logic signed [IN_W-1:0] data_in;
  logic                   frame_sync;
  logic                   stp_valid;
  logic                   frame_drop;
  logic                   sync_slip;
  logic signed [15:0]     po_0, po_1, po_2, po_3, po_4, po_5, po_6, po_7;
  logic signed [15:0]     po_8, po_9, po_10, po_11, po_12, po_13, po_14, po_15;

  modport master (
    output data_valid, data_in, frame_sync,
    input  stp_valid, frame_drop, sync_slip,
    input  po_0, po_1, po_2, po_3, po_4, po_5, po_6, po_7,
    input  po_8, po_9, po_10, po_11, po_12, po_13, po_14, po_15
  );

  modport slave (
    input  data_valid, data_in, frame_sync,
    output stp_valid, frame_drop, sync_slip,
    output po_0, po_1, po_2, po_3, po_4, po_5, po_6, po_7,
    output po_8, po_9, po_10, po_11, po_12, po_13, po_14, po_15
  );
endinterface

// File: rtl/stp_frame_collector.sv
// stp_frame_collector: gathers 16 signed samples into a frame for the FFT.
// A completed frame is published on po_* with a one-cycle stp_valid and then
// frozen for HOLD_CYC cycles; a frame completing inside that window is dropped.
// Optional feature macro STP_SAT_EN: saturate samples to 16 bits instead of
// keeping the low 16 bits.
module stp_frame_collector #(
  parameter int IN_W     = 18,
  parameter int HOLD_CYC = 7
) (
  input logic                clk,
  input logic                rst,
  stp_frame_collector_if.slave bus
);

  localparam int GW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  logic        [3:0]    cnt;
  logic        [GW-1:0] guard;
  logic signed [15:0]   buf_q [15];
  logic signed [15:0]   po_q  [16];
  logic signed [15:0]   sample;
  logic                 stp_valid_q;
  logic                 frame_drop_q;
  logic                 sync_slip_q;

`ifdef STP_SAT_EN
  logic [IN_W-16:0] hi_bits;

  // Clamp to the 16-bit range when the upper bits are not pure sign extension.
  always_comb begin
    hi_bits = bus.data_in[IN_W-1:15];
    sample  = bus.data_in[15:0];
    if (!((&hi_bits) || !(|hi_bits))) begin
      sample = bus.data_in[IN_W-1] ? 16'sh8000 : 16'sh7FFF;
    end
  end
`else
  logic unused_hi;

  // Plain two's-complement truncation; the upper bits are intentionally dropped.
  assign sample    = bus.data_in[15:0];
  assign unused_hi = ^bus.data_in;
`endif

  // Sample accept, frame publish/drop, resync and hold-window countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      guard        <= '0;
      stp_valid_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      sync_slip_q  <= 1'b0;
      for (int k = 0; k < 15; k++) buf_q[k] <= '0;
      for (int k = 0; k < 16; k++) po_q[k]  <= '0;
    end else begin
      stp_valid_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      sync_slip_q  <= 1'b0;
      if (guard != '0) guard <= guard - 1'b1;

      if (bus.data_valid) begin
        if (bus.frame_sync && (cnt != 4'd0)) begin
          // Resync: the new sample becomes index 0 of a fresh frame.
          buf_q[0]    <= sample;
          cnt         <= 4'd1;
          sync_slip_q <= 1'b1;
        end else if (cnt == 4'd15) begin
          cnt <= 4'd0;
          if (guard == '0) begin
            for (int k = 0; k < 15; k++) po_q[k] <= buf_q[k];
            po_q[15]    <= sample;
            stp_valid_q <= 1'b1;
            guard       <= GW'(HOLD_CYC);
          end else begin
            frame_drop_q <= 1'b1;
          end
        end else begin
          buf_q[cnt] <= sample;
          cnt        <= cnt + 4'd1;
        end
      end
    end
  end

  assign bus.stp_valid  = stp_valid_q;
  assign bus.frame_drop = frame_drop_q;
  assign bus.sync_slip  = sync_slip_q;
  assign bus.po_0  = po_q[0];
  assign bus.po_1  = po_q[1];
  assign bus.po_2  = po_q[2];
  assign bus.po_3  = po_q[3];
  assign bus.po_4  = po_q[4];
  assign bus.po_5  = po_q[5];
  assign bus.po_6  = po_q[6];
  assign bus.po_7  = po_q[7];
  assign bus.po_8  = po_q[8];
  assign bus.po_9  = po_q[9];
  assign bus.po_10 = po_q[10];
  assign bus.po_11 = po_q[11];
  assign bus.po_12 = po_q[12];
  assign bus.po_13 = po_q[13];
  assign bus.po_14 = po_q[14];
  assign bus.po_15 = po_q[15];

endmodule

// File: tb/tb_stp_frame_collector.sv
// Directed bench for stp_frame_collector. Two instances share the stimulus:
// dut_a (HOLD_CYC=7) is the main subject, dut_b (HOLD_CYC=20) exercises drops.
module tb_stp_frame_collector;
  localparam int IN_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stp_frame_collector_if #(.IN_W(IN_W)) ifa ();
  stp_frame_collector_if #(.IN_W(IN_W)) ifb ();

  stp_frame_collector #(.IN_W(IN_W), .HOLD_CYC(7))  dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  stp_frame_collector #(.IN_W(IN_W), .HOLD_CYC(20)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic signed [15:0] pa [16];
  assign pa[0]  = ifa.po_0;  assign pa[1]  = ifa.po_1;  assign pa[2]  = ifa.po_2;
  assign pa[3]  = ifa.po_3;  assign pa[4]  = ifa.po_4;  assign pa[5]  = ifa.po_5;
  assign pa[6]  = ifa.po_6;  assign pa[7]  = ifa.po_7;  assign pa[8]  = ifa.po_8;
  assign pa[9]  = ifa.po_9;  assign pa[10] = ifa.po_10; assign pa[11] = ifa.po_11;
  assign pa[12] = ifa.po_12; assign pa[13] = ifa.po_13; assign pa[14] = ifa.po_14;
  assign pa[15] = ifa.po_15;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs on both instances; outputs settle #1 after the edge.
  task automatic drive(input bit dv, input int v, input bit sync);
    ifa.data_valid = dv; ifa.data_in = IN_W'(v); ifa.frame_sync = sync;
    ifb.data_valid = dv; ifb.data_in = IN_W'(v); ifb.frame_sync = sync;
    @(posedge clk);
    #1;
  endtask

  logic signed [15:0] snap [16];
  int pulses, last_pos, changed, gap_bad;

  initial begin
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    chk("rst_stp_valid", int'(ifa.stp_valid), 0);
    chk("rst_frame_drop", int'(ifa.frame_drop), 0);
    chk("rst_sync_slip", int'(ifa.sync_slip), 0);
    chk("rst_po_0", int'(ifa.po_0), 0);
    chk("rst_po_15", int'(ifa.po_15), 0);
    rst = 1'b0;

    // 1: single frame 1..16
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, i, 1'b0);
      if (i < 16 && ifa.stp_valid) pulses++;
    end
    chk("t1_early_pulse", pulses, 0);
    chk("t1_stp_valid", int'(ifa.stp_valid), 1);
    chk("t1_frame_drop", int'(ifa.frame_drop), 0);
    chk("t1_po_0", int'(ifa.po_0), 1);
    chk("t1_po_7", int'(ifa.po_7), 8);
    chk("t1_po_15", int'(ifa.po_15), 16);
    drive(1'b0, 0, 1'b0);
    chk("t1_pulse_clear", int'(ifa.stp_valid), 0);

    // 2: 48 continuous samples, then idle; pulses 16 apart, po frozen between
    pulses = 0; last_pos = -1; changed = 0; gap_bad = 0;
    for (int i = 0; i < 63; i++) begin
      drive(i < 48, 1000 + i, 1'b0);
      if (ifa.stp_valid) begin
        if (last_pos >= 0 && i - last_pos != 16) gap_bad++;
        if (ifa.frame_drop) gap_bad++;
        pulses++;
        last_pos = i;
        for (int k = 0; k < 16; k++) snap[k] = pa[k];
      end else if (pulses > 0) begin
        for (int k = 0; k < 16; k++) if (pa[k] != snap[k]) changed++;
      end
    end
    chk("t2_pulses", pulses, 3);
    chk("t2_last_pos", last_pos, 47);
    chk("t2_gap", gap_bad, 0);
    chk("t2_po_changed", changed, 0);
    chk("t2_po_0", int'(ifa.po_0), 1032);
    chk("t2_po_15", int'(ifa.po_15), 1047);

    // 3: resync after 5 samples
    for (int i = 0; i < 5; i++) drive(1'b1, 2000 + i, 1'b0);
    chk("t3_no_slip_yet", int'(ifa.sync_slip), 0);
    drive(1'b1, 100, 1'b1);
    chk("t3_sync_slip", int'(ifa.sync_slip), 1);
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, 100 + i, 1'b0);
      if (i == 1) chk("t3_slip_clear", int'(ifa.sync_slip), 0);
      if (i < 15 && ifa.stp_valid) pulses++;
    end
    chk("t3_early_pulse", pulses, 0);
    chk("t3_stp_valid", int'(ifa.stp_valid), 1);
    chk("t3_po_0", int'(ifa.po_0), 100);
    chk("t3_po_1", int'(ifa.po_1), 101);
    chk("t3_po_15", int'(ifa.po_15), 115);

    // 4: frame, 2 idle, then a synced frame; HOLD 7 accepts, HOLD 20 drops
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) drive(1'b1, 300 + i, 1'b0);
    chk("t4_a_first", int'(ifa.stp_valid), 1);
    chk("t4_b_first", int'(ifb.stp_valid), 1);
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    drive(1'b1, 400, 1'b1);
    chk("t4_no_slip", int'(ifa.sync_slip), 0);
    for (int i = 1; i < 16; i++) drive(1'b1, 400 + i, 1'b0);
    chk("t4_a_stp_valid", int'(ifa.stp_valid), 1);
    chk("t4_a_frame_drop", int'(ifa.frame_drop), 0);
    chk("t4_a_po_0", int'(ifa.po_0), 400);
    chk("t4_b_stp_valid", int'(ifb.stp_valid), 0);
    chk("t4_b_frame_drop", int'(ifb.frame_drop), 1);
    chk("t4_b_po_0", int'(ifb.po_0), 300);
    chk("t4_b_po_15", int'(ifb.po_15), 315);
    drive(1'b0, 0, 1'b0);
    chk("t4_b_drop_clear", int'(ifb.frame_drop), 0);

    // 5: reset after 10 samples
    for (int i = 0; i < 10; i++) drive(1'b1, 50 + i, 1'b0);
    rst = 1'b1;
    drive(1'b1, 60, 1'b0);
    chk("t5_rst_po_0", int'(ifa.po_0), 0);
    chk("t5_rst_po_15", int'(ifa.po_15), 0);
    chk("t5_rst_stp_valid", int'(ifa.stp_valid), 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive(i < 16, 200 + i, 1'b0);
      if (ifa.stp_valid) begin
        pulses++;
        chk("t5_pulse_pos", i, 15);
      end
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_po_0", int'(ifa.po_0), 200);
    chk("t5_po_9", int'(ifa.po_9), 209);
    chk("t5_po_15", int'(ifa.po_15), 215);

    // 6: out-of-range samples and 16-bit extremes
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       drive(1'b1, 40000, 1'b0);
        1:       drive(1'b1, -40000, 1'b0);
        2:       drive(1'b1, 32767, 1'b0);
        15:      drive(1'b1, -32768, 1'b0);
        default: drive(1'b1, 0, 1'b0);
      endcase
    end
    chk("t6_stp_valid", int'(ifa.stp_valid), 1);
`ifdef STP_SAT_EN
    chk("t6_pos_sat", int'(ifa.po_0), 32767);
    chk("t6_neg_sat", int'(ifa.po_1), -32768);
`else
    chk("t6_pos_wrap", int'(ifa.po_0), -25536);
    chk("t6_neg_wrap", int'(ifa.po_1), 25536);
`endif
    chk("t6_max", int'(ifa.po_2), 32767);
    chk("t6_min", int'(ifa.po_15), -32768);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
